ceespu_mem_stage: RTL

- Memory-access stage directly downstream of the ceespu ALU.
- Consumes the ALU adder result as the effective address and the data result as the pass-through value.
- Performs loads and stores over a simple req/ack data bus, with byte-lane steering and sign/zero extension.
- Stalls the upstream pipeline while a bus transaction is outstanding, and presents one registered writeback record per retired instruction.

---
 rtl/ceespu_mem_stage.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ceespu_mem_stage.sv
// ceespu_mem_stage
// ----------------
// Memory-access stage of the ceespu pipeline. It sits directly after the ALU
// and either passes the ALU result through to writeback or performs one load
// or store over a simple req/ack data bus.
//
// Ports:
//   I_clk, I_rst_n       clock (posedge) and synchronous active-low reset
//   I_valid              instruction present from execute
//   I_memop              0 none, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 SW, 7 SH, 8 SB
//                        (9-15 behave as none)
//   I_addr               effective address from the ALU adder
//   I_aluResult          value written back for non-memory instructions
//   I_storeData          store source register value
//   I_rd, I_regWrite     destination register and its write enable
//   O_stall              combinational freeze of the upstream pipeline
//   O_mem_*              registered bus request: req, we, word address,
//                        lane-replicated write data, byte enables
//   I_mem_ack            one-cycle bus completion pulse
//   I_mem_rdata          read data, valid together with I_mem_ack
//   O_wb_*               registered writeback record; O_wb_valid is a pulse
//   O_misaligned         pulse for a misaligned access (no bus traffic)
//   O_bus_error          pulse when a bus transaction times out
//
// TIMEOUT is the number of WAIT cycles without an ack before O_bus_error is
// raised; 0 disables the timeout.

module ceespu_mem_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_valid,
    input  logic [3:0]  I_memop,
    input  logic [31:0] I_addr,
    input  logic [31:0] I_aluResult,
    input  logic [31:0] I_storeData,
    input  logic [4:0]  I_rd,
    input  logic        I_regWrite,
    output logic        O_stall,
    output logic        O_mem_req,
    output logic        O_mem_we,
    output logic [31:0] O_mem_addr,
    output logic [31:0] O_mem_wdata,
    output logic [3:0]  O_mem_be,
    input  logic        I_mem_ack,
    input  logic [31:0] I_mem_rdata,
    output logic        O_wb_valid,
    output logic        O_wb_we,
    output logic [4:0]  O_wb_rd,
    output logic [31:0] O_wb_data,
    output logic        O_misaligned,
    output logic        O_bus_error
);

    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LB  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;

    // When TIMEOUT is 0 this wraps to all-ones, but the compare is gated off.
    localparam logic [31:0] COUNT_LIMIT = 32'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t      r_state, w_stateNext;
    logic [31:0] r_count, w_countNext;
    logic [3:0]  r_memop, w_memopNext;
    logic [1:0]  r_lane, w_laneNext;
    logic [4:0]  r_rd, w_rdNext;
    logic        r_regWrite, w_regWriteNext;

    logic        r_memReq, w_memReqNext;
    logic        r_memWe, w_memWeNext;
    logic [31:0] r_memAddr, w_memAddrNext;
    logic [31:0] r_memWdata, w_memWdataNext;
    logic [3:0]  r_memBe, w_memBeNext;
    logic        r_wbValid, w_wbValidNext;
    logic        r_wbWe, w_wbWeNext;
    logic [4:0]  r_wbRd, w_wbRdNext;
    logic [31:0] r_wbData, w_wbDataNext;
    logic        r_misaligned, w_misalignedNext;
    logic        r_busError, w_busErrorNext;

    logic        w_isLoad, w_isStore, w_isMem, w_misaligned;
    logic        w_latchedIsLoad, w_timeoutHit;
    logic [3:0]  w_storeBe;
    logic [31:0] w_storeWdata, w_loadData;
    logic [7:0]  w_loadByte;
    logic [15:0] w_loadHalf;

    assign w_isLoad  = (I_memop >= OP_LW) && (I_memop <= OP_LBU);
    assign w_isStore = (I_memop >= OP_SW) && (I_memop <= OP_SB);
    assign w_isMem   = w_isLoad || w_isStore;
    assign w_misaligned =
        (((I_memop == OP_LW) || (I_memop == OP_SW)) && (I_addr[1:0] != 2'b00)) ||
        (((I_memop == OP_LH) || (I_memop == OP_LHU) || (I_memop == OP_SH)) && I_addr[0]);

    assign w_latchedIsLoad = (r_memop >= OP_LW) && (r_memop <= OP_LBU);

    // Ack in the same cycle as the last allowed WAIT cycle wins over timeout.
    assign w_timeoutHit = (TIMEOUT != 0) && (r_state == S_WAIT) && !I_mem_ack &&
                          (r_count == COUNT_LIMIT);

    // Stall drops in the ack/timeout cycle so upstream advances on that edge.
    assign O_stall = ((r_state == S_IDLE) && I_valid && w_isMem && !w_misaligned) ||
                     ((r_state == S_WAIT) && !I_mem_ack && !w_timeoutHit);

    // Byte-lane steering: narrow stores are replicated across the word and
    // the byte enables pick the lane the memory actually writes.
    always_comb begin
        w_storeBe    = 4'b1111;
        w_storeWdata = 32'h0;
        case (I_memop)
            OP_SW: begin
                w_storeBe    = 4'b1111;
                w_storeWdata = I_storeData;
            end
            OP_SH: begin
                w_storeBe    = I_addr[1] ? 4'b1100 : 4'b0011;
                w_storeWdata = {2{I_storeData[15:0]}};
            end
            OP_SB: begin
                w_storeBe    = 4'b0001 << I_addr[1:0];
                w_storeWdata = {4{I_storeData[7:0]}};
            end
            default: begin
                w_storeBe    = 4'b1111;
                w_storeWdata = 32'h0;
            end
        endcase
    end

    // Load extraction uses the lane latched at issue, not the live address.
    always_comb begin
        w_loadHalf = r_lane[1] ? I_mem_rdata[31:16] : I_mem_rdata[15:0];
        case (r_lane)
            2'd0:    w_loadByte = I_mem_rdata[7:0];
            2'd1:    w_loadByte = I_mem_rdata[15:8];
            2'd2:    w_loadByte = I_mem_rdata[23:16];
            default: w_loadByte = I_mem_rdata[31:24];
        endcase
        case (r_memop)
            OP_LH:   w_loadData = {{16{w_loadHalf[15]}}, w_loadHalf};
            OP_LHU:  w_loadData = {16'h0, w_loadHalf};
            OP_LB:   w_loadData = {{24{w_loadByte[7]}}, w_loadByte};
            OP_LBU:  w_loadData = {24'h0, w_loadByte};
            default: w_loadData = I_mem_rdata;
        endcase
    end

    // Next-state and next-output logic. Bus outputs hold by default so they
    // stay stable through WAIT; the writeback and exception flags are pulses.
    always_comb begin
        w_stateNext      = r_state;
        w_countNext      = r_count;
        w_memopNext      = r_memop;
        w_laneNext       = r_lane;
        w_rdNext         = r_rd;
        w_regWriteNext   = r_regWrite;
        w_memReqNext     = r_memReq;
        w_memWeNext      = r_memWe;
        w_memAddrNext    = r_memAddr;
        w_memWdataNext   = r_memWdata;
        w_memBeNext      = r_memBe;
        w_wbValidNext    = 1'b0;
        w_wbWeNext       = 1'b0;
        w_wbRdNext       = r_wbRd;
        w_wbDataNext     = r_wbData;
        w_misalignedNext = 1'b0;
        w_busErrorNext   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (I_valid) begin
                    if (!w_isMem) begin
                        w_wbValidNext = 1'b1;
                        w_wbWeNext    = I_regWrite;
                        w_wbRdNext    = I_rd;
                        w_wbDataNext  = I_aluResult;
                    end else if (w_misaligned) begin
                        w_misalignedNext = 1'b1;
                    end else begin
                        w_stateNext    = S_WAIT;
                        w_countNext    = 32'h0;
                        w_memopNext    = I_memop;
                        w_laneNext     = I_addr[1:0];
                        w_rdNext       = I_rd;
                        w_regWriteNext = I_regWrite;
                        w_memReqNext   = 1'b1;
                        w_memWeNext    = w_isStore;
                        w_memAddrNext  = {I_addr[31:2], 2'b00};
                        w_memWdataNext = w_storeWdata;
                        w_memBeNext    = w_storeBe;
                    end
                end
            end
            S_WAIT: begin
                if (I_mem_ack) begin
                    w_stateNext   = S_IDLE;
                    w_memReqNext  = 1'b0;
                    w_memWeNext   = 1'b0;
                    w_wbValidNext = 1'b1;
                    w_wbRdNext    = r_rd;
                    w_wbWeNext    = w_latchedIsLoad && r_regWrite;
                    w_wbDataNext  = w_latchedIsLoad ? w_loadData : 32'h0;
                end else if (w_timeoutHit) begin
                    w_stateNext    = S_IDLE;
                    w_memReqNext   = 1'b0;
                    w_memWeNext    = 1'b0;
                    w_busErrorNext = 1'b1;
                    w_wbValidNext  = 1'b1;
                    w_wbRdNext     = r_rd;
                    w_wbDataNext   = 32'h0;
                end else begin
                    w_countNext = r_count + 32'd1;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    // State and output registers; reset clears everything including any
    // in-flight request.
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            r_state      <= S_IDLE;
            r_count      <= 32'h0;
            r_memop      <= 4'h0;
            r_lane       <= 2'b00;
            r_rd         <= 5'h0;
            r_regWrite   <= 1'b0;
            r_memReq     <= 1'b0;
            r_memWe      <= 1'b0;
            r_memAddr    <= 32'h0;
            r_memWdata   <= 32'h0;
            r_memBe      <= 4'h0;
            r_wbValid    <= 1'b0;
            r_wbWe       <= 1'b0;
            r_wbRd       <= 5'h0;
            r_wbData     <= 32'h0;
            r_misaligned <= 1'b0;
            r_busError   <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_count      <= w_countNext;
            r_memop      <= w_memopNext;
            r_lane       <= w_laneNext;
            r_rd         <= w_rdNext;
            r_regWrite   <= w_regWriteNext;
            r_memReq     <= w_memReqNext;
            r_memWe      <= w_memWeNext;
            r_memAddr    <= w_memAddrNext;
            r_memWdata   <= w_memWdataNext;
            r_memBe      <= w_memBeNext;
            r_wbValid    <= w_wbValidNext;
            r_wbWe       <= w_wbWeNext;
            r_wbRd       <= w_wbRdNext;
            r_wbData     <= w_wbDataNext;
            r_misaligned <= w_misalignedNext;
            r_busError   <= w_busErrorNext;
        end
    end

    assign O_mem_req    = r_memReq;
    assign O_mem_we     = r_memWe;
    assign O_mem_addr   = r_memAddr;
    assign O_mem_wdata  = r_memWdata;
    assign O_mem_be     = r_memBe;
    assign O_wb_valid   = r_wbValid;
    assign O_wb_we      = r_wbWe;
    assign O_wb_rd      = r_wbRd;
    assign O_wb_data    = r_wbData;
    assign O_misaligned = r_misaligned;
    assign O_bus_error  = r_busError;

endmodule
